// File: rtl/uart_rx_engine_pkg.sv
// Shared types for the UART receive path: FSM states, latched frame
// configuration, FIFO entry layout and small bit-level helpers.
package uart_rx_engine_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BRK_WAIT
  } rx_state_e;

  // One received character as stored in the receive FIFO.
  typedef struct packed {
    logic [7:0] data;
    logic       pe;
    logic       fe;
    logic       bi;
  } rx_entry_t;

  // Line settings captured at start detection and held for the frame.
  typedef struct packed {
    logic [3:0] len;
    logic       stop2;
    logic       par_en;
    logic       par_sel;
    logic       stick_par;
  } rx_cfg_t;

  // charl 00/01/10/11 selects 5/6/7/8 data bits.
  function automatic logic [3:0] charl_to_len(input logic [1:0] charl);
    return 4'd5 + {2'b00, charl};
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive FIFO, first-word-fall-through. The head reads as zero while empty.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module uart_rx_fifo
  import uart_rx_engine_pkg::*;
#(
  parameter int  DEPTH   = 16,
  parameter type entry_t = rx_entry_t
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  entry_t                 push_data_i,
  input  logic                   pop_i,
  output entry_t                 head_o,
  output logic                   empty_o,
  output logic                   full_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);

  // One extra pointer bit tells full from empty; the low bits wrap modulo DEPTH.
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  entry_t      mem_q [DEPTH];
  logic        do_push;
  logic        do_pop;

  assign count_o = wr_ptr_q - rd_ptr_q;
  assign empty_o = (count_o == '0);
  assign full_o  = (count_o == (AW + 1)'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign head_o  = empty_o ? entry_t'('0) : mem_q[rd_ptr_q[AW-1:0]];

  // Pointer advance for accepted pushes and pops.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  // Pointer registers; clearing them empties the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage write.
  // NOTE: storage has no reset; empty pointers already hide stale words and the head mux forces zero.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/uart_rx_engine.sv
// UART receiver: synchronizes srx, oversamples on baud_tick, frames 5-8 data
// bits with optional parity, detects break and queues characters with their
// error flags into a FIFO with sticky overrun.
module uart_rx_engine
  import uart_rx_engine_pkg::*;
#(
  parameter int SAMPLE_CYCLES = 16,
  parameter int FIFO_DEPTH    = 16,
  parameter int MAJORITY      = 1
) (
  input  logic                        uart_clk,
  input  logic                        uart_rst_n,
  input  logic                        baud_tick,
  input  logic                        srx,
  input  logic [1:0]                  charl,
  input  logic                        stop_bits,
  input  logic                        par_en,
  input  logic                        par_sel,
  input  logic                        stick_par,
  input  logic                        rd_en,
  input  logic                        lsr_clr,
  output logic [7:0]                  rd_data,
  output logic                        rd_pe,
  output logic                        rd_fe,
  output logic                        rd_bi,
  output logic                        rcv_dr,
  output logic                        ovre,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        rx_busy
);

  localparam int            CW       = $clog2(SAMPLE_CYCLES);
  localparam logic [CW-1:0] CNT_MID  = CW'(SAMPLE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(SAMPLE_CYCLES / 2 - 1);

  logic            srx_meta_q, srx_sync_q;
  rx_state_e       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      hist_q, hist_d;      // [0] = previous tick sample, [1] = the one before
  rx_cfg_t         cfg_q, cfg_d;
  logic [7:0]      data_q, data_d;
  logic [2:0]      widx_q, widx_d;
  logic [3:0]      nbits_q, nbits_d;
  logic            pend_data_q, pend_data_d;
  logic            pend_par_q, pend_par_d;
  logic            par_q, par_d;
  logic            ovre_q, ovre_d;

  logic            bit_val;
  logic            par_exp;
  logic            is_break;
  logic            push_req;
  rx_entry_t       push_entry;
  rx_entry_t       fifo_head;
  logic            fifo_full;
  logic            fifo_empty;

  // stop_bits is captured with the frame settings but never alters receive timing.
  logic            unused_stop2;
  assign unused_stop2 = cfg_q.stop2;

  // Two-flop synchronizer; resets low so a line held low needs a rising edge first.
  // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge uart_clk or negedge uart_rst_n) begin
    if (!uart_rst_n) begin
      srx_meta_q <= 1'b0;
      srx_sync_q <= 1'b0;
    end else begin
      srx_meta_q <= srx;
      srx_sync_q <= srx_meta_q;
    end
  end

  // Bit decision, made on the tick after mid-bit: majority of mid-1/mid/mid+1 or mid alone.
  always_comb begin
    if (MAJORITY != 0) bit_val = maj3(hist_q[1], hist_q[0], srx_sync_q);
    else               bit_val = hist_q[0];
  end

  assign par_exp  = cfg_q.stick_par ? ~cfg_q.par_sel
                                    : (cfg_q.par_sel ? ^data_q : ~^data_q);
  assign is_break = (data_q == 8'h00) && !(cfg_q.par_en && par_q) && !srx_sync_q;

  // Frame FSM next-state and push generation; all movement happens on baud_tick.
  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hist_d      = hist_q;
    cfg_d       = cfg_q;
    data_d      = data_q;
    widx_d      = widx_q;
    nbits_d     = nbits_q;
    pend_data_d = pend_data_q;
    pend_par_d  = pend_par_q;
    par_d       = par_q;
    push_req    = 1'b0;
    push_entry  = '0;

    if (baud_tick) begin
      hist_d = {hist_q[0], srx_sync_q};

      // Resolve a bit whose mid sample was taken on the previous tick.
      if (pend_data_q) begin
        data_d[widx_q] = bit_val;
        widx_d         = widx_q + 3'd1;
        pend_data_d    = 1'b0;
      end
      if (pend_par_q) begin
        par_d      = bit_val;
        pend_par_d = 1'b0;
      end

      unique case (state_q)
        IDLE: begin
          if (hist_q[0] && !srx_sync_q) begin
            state_d = START;
            cnt_d   = '0;
            cfg_d   = '{len:       charl_to_len(charl),
                        stop2:     stop_bits,
                        par_en:    par_en,
                        par_sel:   par_sel,
                        stick_par: stick_par};
          end
        end
        START: begin
          if (cnt_q == CNT_HALF) begin
            cnt_d = '0;
            if (!srx_sync_q) begin
              state_d = DATA;
              data_d  = '0;
              widx_d  = '0;
              nbits_d = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (cnt_q == CNT_MID) begin
            cnt_d       = '0;
            pend_data_d = 1'b1;
            nbits_d     = nbits_q + 4'd1;
            if (nbits_q == cfg_q.len - 4'd1) state_d = cfg_q.par_en ? PARITY : STOP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        PARITY: begin
          if (cnt_q == CNT_MID) begin
            cnt_d      = '0;
            pend_par_d = 1'b1;
            state_d    = STOP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        STOP: begin
          if (cnt_q == CNT_MID) begin
            cnt_d    = '0;
            push_req = 1'b1;
            if (is_break) begin
              push_entry.fe = 1'b1;
              push_entry.bi = 1'b1;
              state_d       = BRK_WAIT;
            end else begin
              push_entry.data = data_q;
              push_entry.pe   = cfg_q.par_en && (par_q != par_exp);
              push_entry.fe   = !srx_sync_q;
              state_d         = IDLE;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        BRK_WAIT: begin
          if (srx_sync_q) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Frame FSM and datapath registers.
  always_ff @(posedge uart_clk or negedge uart_rst_n) begin
    if (!uart_rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      hist_q      <= '0;
      cfg_q       <= '0;
      data_q      <= '0;
      widx_q      <= '0;
      nbits_q     <= '0;
      pend_data_q <= 1'b0;
      pend_par_q  <= 1'b0;
      par_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hist_q      <= hist_d;
      cfg_q       <= cfg_d;
      data_q      <= data_d;
      widx_q      <= widx_d;
      nbits_q     <= nbits_d;
      pend_data_q <= pend_data_d;
      pend_par_q  <= pend_par_d;
      par_q       <= par_d;
    end
  end

  // Sticky overrun: a new overrun wins over a simultaneous clear.
  always_comb begin
    ovre_d = ovre_q;
    if (lsr_clr) ovre_d = 1'b0;
    if (push_req && fifo_full && !rd_en) ovre_d = 1'b1;
  end

  // Overrun flag register.
  always_ff @(posedge uart_clk or negedge uart_rst_n) begin
    if (!uart_rst_n) ovre_q <= 1'b0;
    else             ovre_q <= ovre_d;
  end

  uart_rx_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (rx_entry_t)
  ) u_fifo (
    .clk         (uart_clk),
    .rst_n       (uart_rst_n),
    .push_i      (push_req),
    .push_data_i (push_entry),
    .pop_i       (rd_en),
    .head_o      (fifo_head),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full),
    .count_o     (fifo_count)
  );

  assign rd_data = fifo_head.data;
  assign rd_pe   = fifo_head.pe;
  assign rd_fe   = fifo_head.fe;
  assign rd_bi   = fifo_head.bi;
  assign rcv_dr  = !fifo_empty;
  assign ovre    = ovre_q;
  assign rx_busy = (state_q != IDLE);

endmodule
